// File: rtl/free_list_pkg.sv
// Shared sizes, packet types and pointer helpers for the physical-register free list.
package free_list_pkg;

    localparam int NUM_PR   = 64;
    localparam int NUM_FL   = 32;
    localparam int PR_W     = $clog2(NUM_PR);
    localparam int FL_IDX_W = $clog2(NUM_FL);
    localparam int FL_PTR_W = FL_IDX_W + 1;

    typedef logic [PR_W-1:0]     pr_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;

    typedef struct packed {
        logic    dispatch_en;
        logic    retire_en;
        pr_t     t_old_in;
        logic    rollback_en;
        fl_ptr_t rollback_head;
    } free_list_packet_in_t;

    typedef struct packed {
        pr_t     t_out;
        logic    t_valid;
        fl_ptr_t head_out;
        fl_ptr_t free_count;
    } free_list_packet_out_t;

    // After reset the list holds every PR above the architectural ones: 32..63.
    localparam fl_ptr_t HEAD_RST   = '0;
    localparam fl_ptr_t TAIL_RST   = fl_ptr_t'(NUM_FL);
    localparam fl_ptr_t FULL_COUNT = fl_ptr_t'(NUM_FL);
    localparam fl_ptr_t PTR_ONE    = fl_ptr_t'(1);

    function automatic pr_t reset_entry(input int i);
        return pr_t'(NUM_FL + i);
    endfunction

    // Wrap bit makes tail - head an unambiguous 0..32 occupancy.
    function automatic fl_ptr_t occupancy(input fl_ptr_t tail, input fl_ptr_t head);
        return tail - head;
    endfunction

    function automatic fl_idx_t ptr_idx(input fl_ptr_t p);
        return p[FL_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers: pop at dispatch, push at retire,
// head restore on branch rollback, sticky flag on push while full.
module free_list
    import free_list_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                dispatch_en_i,
    input  logic                retire_en_i,
    input  logic [PR_W-1:0]     t_old_in_i,
    input  logic                rollback_en_i,
    input  logic [FL_PTR_W-1:0] rollback_head_i,
    output logic [PR_W-1:0]     t_out_o,
    output logic                t_valid_o,
    output logic [FL_PTR_W-1:0] head_out_o,
    output logic [FL_PTR_W-1:0] free_count_o,
    output logic                overflow_err_o
);

    free_list_packet_in_t  pkt_in;
    free_list_packet_out_t pkt_out;

    pr_t     entries_q [NUM_FL];
    pr_t     entries_d [NUM_FL];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    logic    overflow_q, overflow_d;

    fl_ptr_t count;
    logic    empty;
    logic    full;
    logic    do_pop;
    logic    do_push;
    logic    push_rejected;

    assign pkt_in.dispatch_en   = dispatch_en_i;
    assign pkt_in.retire_en     = retire_en_i;
    assign pkt_in.t_old_in      = t_old_in_i;
    assign pkt_in.rollback_en   = rollback_en_i;
    assign pkt_in.rollback_head = rollback_head_i;

    // Push and pop both judge against pre-edge occupancy, so there is no bypass.
    always_comb begin
        count         = occupancy(tail_q, head_q);
        empty         = (count == '0);
        full          = (count == FULL_COUNT);
        do_pop        = en_i && pkt_in.dispatch_en && !empty && !pkt_in.rollback_en;
        do_push       = en_i && pkt_in.retire_en && !full;
        push_rejected = en_i && pkt_in.retire_en && full;
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        entries_d  = entries_q;
        overflow_d = overflow_q | push_rejected;

        if (en_i && pkt_in.rollback_en) begin
            head_d = pkt_in.rollback_head;
        end else if (do_pop) begin
            head_d = head_q + PTR_ONE;
        end

        if (do_push) begin
            entries_d[ptr_idx(tail_q)] = pkt_in.t_old_in;
            tail_d                     = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_FL; i++) begin
                entries_q[i] <= reset_entry(i);
            end
            head_q     <= HEAD_RST;
            tail_q     <= TAIL_RST;
            overflow_q <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        pkt_out.t_out      = entries_q[ptr_idx(head_q)];
        pkt_out.t_valid    = !empty;
        pkt_out.head_out   = head_q;
        pkt_out.free_count = count;
    end

    assign t_out_o        = pkt_out.t_out;
    assign t_valid_o      = pkt_out.t_valid;
    assign head_out_o     = pkt_out.head_out;
    assign free_count_o   = pkt_out.free_count;
    assign overflow_err_o = overflow_q;

endmodule
